// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC generator: owns the fetch PC, predicts redirects from a
// direct-mapped BTB with 2-bit direction counters, and trains on execute outcomes.
module next_pc_predictor #(
    parameter int unsigned    XLEN        = 32,
    parameter int unsigned    BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;
    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [XLEN-1:0]  correct_target;
    logic             mispredict;

    logic             wr_en;
    logic             wr_alloc;
    logic             wr_target;
    logic [1:0]       wr_ctr;

    // Bit 0 of the ALU target is never part of a fetch address.
    logic unused_bits;
    assign unused_bits = ex_target[0];

    assign fetch_idx      = pc[IDX+1:2];
    assign fetch_tag      = pc[XLEN-1:IDX+2];
    assign ex_idx         = ex_pc[IDX+1:2];
    assign ex_tag         = ex_pc[XLEN-1:IDX+2];
    assign correct_target = {ex_target[XLEN-1:1], 1'b0};
    assign pc_plus4       = pc + XLEN'(4);

    // Fetch lookup reads pre-write BTB contents.
    always_comb begin
        fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
        pred_target = target_q[fetch_idx];
    end

    // Mispredict detection and recovery address.
    always_comb begin
        mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                      (ex_taken && (ex_pred_target != correct_target)));
        redirect    = mispredict && !rst;
        redirect_pc = ex_taken ? correct_target : ex_pc + XLEN'(4);
    end

    // Training decision for the entry indexed by ex_pc.
    always_comb begin
        ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        wr_en     = 1'b0;
        wr_alloc  = 1'b0;
        wr_target = 1'b0;
        wr_ctr    = ctr_q[ex_idx];
        if (ex_valid && !rst) begin
            if (ex_hit) begin
                if (ex_is_branch) begin
                    wr_en     = 1'b1;
                    wr_target = ex_taken;
                    if (ex_taken) begin
                        wr_ctr = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
                    end else begin
                        wr_ctr = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
                    end
                end else if (ex_is_jal || ex_is_jalr) begin
                    wr_en     = 1'b1;
                    wr_target = 1'b1;
                    wr_ctr    = 2'd3;
                end
            end else if (ex_taken) begin
                wr_en     = 1'b1;
                wr_alloc  = 1'b1;
                wr_target = 1'b1;
                wr_ctr    = ex_is_branch ? 2'd2 : 2'd3;
            end
        end
    end

    // Valid bits are the only BTB state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_alloc) begin
            valid_q[ex_idx] <= 1'b1;
        end
    end

    // BTB payload update; contents are don't-care until the entry is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ctr_q[ex_idx] <= wr_ctr;
        end
        if (wr_target) begin
            target_q[ex_idx] <= correct_target;
        end
        if (wr_alloc) begin
            tag_q[ex_idx] <= ex_tag;
        end
    end

    // Fetch PC: reset, then redirect, then stall, then prediction, then sequential.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (!stall) begin
            pc <= pred_taken ? pred_target : pc_plus4;
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed bench for next_pc_predictor with BTB_ENTRIES=16 and RESET_PC=0.
module tb_next_pc_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    next_pc_predictor #(
        .XLEN(32),
        .BTB_ENTRIES(16),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .ex_valid(ex_valid),
        .ex_pc(ex_pc),
        .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr),
        .ex_taken(ex_taken),
        .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 branch, 1 jal, 2 jalr
    task automatic drive_ex(input logic [31:0] epc, input int kind, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = epc;
        ex_is_branch   = (kind == 0);
        ex_is_jal      = (kind == 1);
        ex_is_jalr     = (kind == 2);
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        #1;
    endtask

    task automatic clear_ex();
        ex_valid       = 1'b0;
        ex_pc          = '0;
        ex_is_branch   = 1'b0;
        ex_is_jal      = 1'b0;
        ex_is_jalr     = 1'b0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
        #1;
    endtask

    // Steer fetch to addr via a not-taken mispredict at addr-4 (no BTB entry there).
    task automatic go_to(input logic [31:0] addr);
        drive_ex(addr - 32'd4, 0, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        clear_ex();
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        clear_ex();

        // Execute inputs during reset must neither redirect nor train.
        drive_ex(32'h0, 0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("redirect_in_rst", 32'(redirect), 32'd0);
        tick();
        rst = 1'b0;
        clear_ex();
        check("pc_reset", pc, 32'h0);
        check("pred_reset", 32'(pred_taken), 32'd0);
        check("pc_plus4", pc_plus4, 32'h4);

        tick(); check("seq_4", pc, 32'h4);
        tick(); check("seq_8", pc, 32'h8);
        tick(); check("seq_c", pc, 32'hC);
        tick(); check("seq_10", pc, 32'h10);

        // Stall holds, mispredict overrides stall.
        stall = 1'b1;
        tick(); check("stall_1", pc, 32'h10);
        tick(); check("stall_2", pc, 32'h10);
        drive_ex(32'h300, 0, 1'b1, 32'h200, 1'b0, 32'h0);
        check("stall_redir", 32'(redirect), 32'd1);
        check("stall_redir_pc", redirect_pc, 32'h200);
        tick();
        stall = 1'b0;
        clear_ex();
        check("pc_200", pc, 32'h200);
        check("tag_miss_200", 32'(pred_taken), 32'd0);

        // Allocate on taken miss.
        drive_ex(32'h20, 0, 1'b1, 32'h80, 1'b0, 32'h0);
        check("alloc_redir", 32'(redirect), 32'd1);
        check("alloc_redir_pc", redirect_pc, 32'h80);
        tick();
        clear_ex();
        check("pc_80", pc, 32'h80);
        go_to(32'h20);
        check("pc_20", pc, 32'h20);
        check("pred_alloc", 32'(pred_taken), 32'd1);
        check("pred_tgt_alloc", pred_target, 32'h80);
        tick();
        check("pred_fetch", pc, 32'h80);

        // Not-taken resolution: ctr 2 -> 1.
        drive_ex(32'h20, 0, 1'b0, 32'h80, 1'b1, 32'h80);
        check("nt_redir", 32'(redirect), 32'd1);
        check("nt_redir_pc", redirect_pc, 32'h24);
        tick();
        clear_ex();
        check("pc_24", pc, 32'h24);
        go_to(32'h20);
        check("pred_ctr1", 32'(pred_taken), 32'd0);

        // Taken twice under stall with correct prediction: ctr 1 -> 2 -> 3.
        stall = 1'b1;
        drive_ex(32'h20, 0, 1'b1, 32'h80, 1'b1, 32'h80);
        check("correct_no_redir", 32'(redirect), 32'd0);
        check("collision_prewrite", 32'(pred_taken), 32'd0);
        tick();
        check("pred_ctr2", 32'(pred_taken), 32'd1);
        tick();
        check("stall_over_pred", pc, 32'h20);
        // One not-taken: ctr 3 -> 2, still predicted taken.
        drive_ex(32'h20, 0, 1'b0, 32'h80, 1'b1, 32'h80);
        check("nt2_redir_pc", redirect_pc, 32'h24);
        tick();
        stall = 1'b0;
        clear_ex();
        check("pc_24b", pc, 32'h24);
        go_to(32'h20);
        check("pred_ctr2b", 32'(pred_taken), 32'd1);
        check("pred_tgt_ctr2b", pred_target, 32'h80);

        // Aliasing: jal at 0x60 evicts 0x20 (index 8).
        drive_ex(32'h60, 1, 1'b1, 32'h400, 1'b0, 32'h0);
        check("jal_redir_pc", redirect_pc, 32'h400);
        tick();
        clear_ex();
        check("pc_400", pc, 32'h400);
        go_to(32'h20);
        check("alias_miss", 32'(pred_taken), 32'd0);
        go_to(32'h60);
        check("alias_hit", 32'(pred_taken), 32'd1);
        check("alias_tgt", pred_target, 32'h400);

        // jalr: target bit 0 cleared; correct repeat prediction does not redirect.
        drive_ex(32'h44, 2, 1'b1, 32'h101, 1'b0, 32'h0);
        check("jalr_redir", 32'(redirect), 32'd1);
        check("jalr_redir_pc", redirect_pc, 32'h100);
        tick();
        clear_ex();
        check("pc_100", pc, 32'h100);
        drive_ex(32'h44, 2, 1'b1, 32'h101, 1'b1, 32'h100);
        check("jalr_repeat", 32'(redirect), 32'd0);
        drive_ex(32'h44, 2, 1'b1, 32'h101, 1'b1, 32'h104);
        check("jalr_wrong_tgt", 32'(redirect), 32'd1);
        clear_ex();
        go_to(32'h44);
        check("jalr_pred", 32'(pred_taken), 32'd1);
        check("jalr_pred_tgt", pred_target, 32'h100);

        // PC wrap.
        go_to(32'hFFFF_FFFC);
        check("pc_top", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        tick();
        check("pc_wrap", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_pc_predictor.md
# next_pc_predictor

Fetch-stage next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the front of the pipeline, owns the architectural fetch PC register, and predicts taken branches, jal and jalr at fetch. It accepts resolved control-flow outcomes from execute, issues a redirect on misprediction, and trains the BTB.

## Interface
- XLEN, 32, datapath/address width
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(BTB_ENTRIES)
- RESET_PC, 0, fetch address loaded by reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold fetch PC (front-end back-pressure)
- pc  out  XLEN  current fetch PC (registered)
- pc_plus4  out  XLEN  pc + 4, combinational
- pred_taken  out  1  BTB predicts current pc redirects
- pred_target  out  XLEN  predicted target; valid when pred_taken=1
- ex_valid  in  1  execute holds a resolved control-flow instruction this cycle
- ex_pc  in  XLEN  PC of that instruction
- ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  instruction class; at most one set
- ex_taken  in  1  actual outcome; 1 for jal/jalr
- ex_target  in  XLEN  computed target (ALU output)
- ex_pred_taken  in  1  pred_taken carried down with the instruction
- ex_pred_target  in  XLEN  pred_target carried down with the instruction
- redirect  out  1  mispredict flush, combinational
- redirect_pc  out  XLEN  correct fetch address when redirect=1

## Operation
- BTB entry: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:0], ctr[1:0]. Index = pc[IDX+1:2].
- Lookup (combinational on pc): hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = entry target.
- Correct target: ex_target with bit 0 forced to 0.
- Mispredict = ex_valid && (ex_pred_taken != ex_taken || (ex_taken && ex_pred_target != correct target)).
- redirect = mispredict && !rst. redirect_pc = ex_taken ? correct target : ex_pc + 4.
- Next-PC priority, highest first:
  - rst → RESET_PC
  - redirect → redirect_pc (overrides stall)
  - stall → pc
  - pred_taken → pred_target
  - otherwise → pc_plus4
- Training on ex_valid && !rst, indexed by ex_pc:
  - Hit, branch: ctr saturating +1 if taken, −1 if not; target ← correct target if taken.
  - Hit, jal/jalr: ctr ← 3; target ← correct target.
  - Miss, taken: allocate (overwrite index) with valid=1, new tag, correct target; ctr ← 2 for branch, 3 for jal/jalr.
  - Miss, not taken: no change.
- Training does not depend on the redirect decision. It also occurs when the prediction was correct.
- Arithmetic: all adds are modulo 2^XLEN; pc wrap from 0xFFFFFFFC to 0 is legal.

## Timing
- Reset values:
  - pc = RESET_PC one edge after rst=1.
  - All valid bits cleared, so pred_taken=0.
  - redirect=0 while rst=1.
  - ctr/target/tag contents are don't-care.
- rst asserted mid-operation: same-cycle ex inputs are ignored (no training, no redirect).
- Redirect latency: redirect asserted in cycle N → pc = redirect_pc in cycle N+1.
- Prediction latency: zero; the predicted target is fetched in the cycle after the lookup.
- Read/write collision: if training writes the index being looked up in the same cycle, the lookup uses pre-write contents. The update is visible next cycle.
- BTB state changes only on clock edges. Stall does not block training.

## Test plan
- Reset and sequential fetch: rst for 1 cycle, RESET_PC=0 → pc=0x0, pred_taken=0; then 3 free cycles → 0x4, 0x8, 0xC.
- Stall and override:
  - stall=1 for 2 cycles at pc=0x10 → pc holds 0x10.
  - Mispredict during stall with redirect_pc=0x200 → pc=0x200 next cycle.
- Allocate on taken miss:
  - Branch ex_pc=0x20, ex_taken=1, ex_target=0x80, ex_pred_taken=0 → redirect=1, redirect_pc=0x80, next pc=0x80.
  - Next visit to 0x20 → pred_taken=1, pred_target=0x80 (ctr=2).
- Direction training:
  - Same branch resolved not taken with ex_pred_taken=1 → redirect_pc=0x24, ctr=1; next visit pred_taken=0.
  - Taken twice → ctr=3; one not-taken → still predicted taken.
- Aliasing and jalr (BTB_ENTRIES=16):
  - 0x20 and 0x60 share index 8; a taken jal at 0x60 evicts 0x20's entry → lookup at 0x20 misses.
  - jalr ex_target=0x101 → redirect_pc=0x100.
  - Correct repeat prediction (pred 0x100) → redirect=0.
